// File: rtl/amdc_pwm_mux_pkg.sv
// Shared types and constants for the PWM source multiplexer with glitch-free switching.
package amdc_pwm_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BLANK = 2'd2,
    ST_APPLY = 2'd3
  } state_t;

  localparam logic [3:0] SEL_DISABLED = 4'hF;
  localparam int         CNT_W        = 16;

  // True when a 4-bit select names an existing source.
  function automatic logic sel_valid(input logic [3:0] sel, input int num_ports);
    return (int'(sel) < num_ports);
  endfunction

endpackage

// File: rtl/amdc_pwm_mux_port.sv
// One output port: picks its source lines, applies the blanking gate and registers the result.
module amdc_pwm_mux_port
  import amdc_pwm_mux_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int LINES     = 6
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [3:0]                 sel,
  input  logic                       blank,
  input  logic [NUM_PORTS*LINES-1:0] pwm_in,
  output logic [LINES-1:0]           pwm_out
);

  logic [LINES-1:0] src;
  logic [LINES-1:0] out_nx;

  // Source selection as an OR of one-hot gated slices.
  always_comb begin
    src = {LINES{1'b0}};
    for (int s = 0; s < NUM_PORTS; s++) begin
      src = src | ((sel == 4'(s)) ? pwm_in[s*LINES +: LINES] : {LINES{1'b0}});
    end
    out_nx = (sel_valid(sel, NUM_PORTS) && !blank) ? src : {LINES{1'b0}};
  end

  // Output register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pwm_out <= {LINES{1'b0}};
    end else begin
      pwm_out <= out_nx;
    end
  end

endmodule

// File: rtl/amdc_pwm_mux_switcher.sv
// Routes inverter PWM sources to output ports; select changes take effect at a carrier peak
// after forcing only the re-routed ports low for BLANK_CYCLES cycles.
module amdc_pwm_mux_switcher
  import amdc_pwm_mux_pkg::*;
#(
  parameter int NUM_PORTS    = 8,
  parameter int LINES        = 6,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [4*NUM_PORTS-1:0]     sel_in,
  input  logic                       commit_req,
  output logic                       commit_ack,
  input  logic                       carrier_sync,
  input  logic [NUM_PORTS*LINES-1:0] pwm_in,
  output logic [NUM_PORTS*LINES-1:0] pwm_out,
  output logic                       busy,
  output logic                       pending,
  output logic [4*NUM_PORTS-1:0]     sel_active,
  output logic [15:0]                switch_cnt
);

  localparam logic [4*NUM_PORTS-1:0] SEL_ALL_OFF = {NUM_PORTS{SEL_DISABLED}};
  localparam logic [CNT_W-1:0]       BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);

  state_t                 state, state_nx;
  logic [4*NUM_PORTS-1:0] shadow, shadow_nx;
  logic [4*NUM_PORTS-1:0] pend_buf, pend_buf_nx;
  logic                   pend_valid, pend_valid_nx;
  logic [NUM_PORTS-1:0]   mask, mask_nx;
  logic [CNT_W-1:0]       blank_cnt, blank_cnt_nx;
  logic [4*NUM_PORTS-1:0] sel_active_nx;
  logic [15:0]            switch_cnt_nx;
  logic                   pending_nx;
  logic [4*NUM_PORTS-1:0] sel_cand;
  logic [NUM_PORTS-1:0]   chg;
  logic [4*NUM_PORTS-1:0] port_sel;
  logic [NUM_PORTS-1:0]   port_blank;

  // Changed-port mask against the select that would be captured this cycle.
  always_comb begin
    sel_cand = commit_req ? sel_in : shadow;
    chg      = {NUM_PORTS{1'b0}};
    for (int d = 0; d < NUM_PORTS; d++) begin
      chg[d] = (sel_cand[d*4 +: 4] != sel_active[d*4 +: 4]);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nx      = state;
    shadow_nx     = shadow;
    pend_buf_nx   = pend_buf;
    pend_valid_nx = pend_valid;
    mask_nx       = mask;
    blank_cnt_nx  = blank_cnt;
    sel_active_nx = sel_active;
    switch_cnt_nx = switch_cnt;
    pending_nx    = pending;
    case (state)
      ST_IDLE: begin
        if (commit_req) begin
          shadow_nx  = sel_in;
          pending_nx = 1'b1;
          state_nx   = ST_ARMED;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ARMED: begin
        shadow_nx  = sel_cand;
        pending_nx = 1'b1;
        if (carrier_sync) begin
          mask_nx      = chg;
          blank_cnt_nx = {CNT_W{1'b0}};
          state_nx     = (chg == {NUM_PORTS{1'b0}}) ? ST_APPLY : ST_BLANK;
        end else begin
          state_nx = ST_ARMED;
        end
      end
      ST_BLANK: begin
        if (commit_req) begin
          pend_buf_nx   = sel_in;
          pend_valid_nx = 1'b1;
          pending_nx    = 1'b1;
        end else begin
          pend_valid_nx = pend_valid;
        end
        if (blank_cnt == BLANK_LAST) begin
          state_nx = ST_APPLY;
        end else begin
          blank_cnt_nx = blank_cnt + CNT_ONE;
        end
      end
      ST_APPLY: begin
        sel_active_nx = shadow;
        switch_cnt_nx = switch_cnt + 16'd1;
        mask_nx       = {NUM_PORTS{1'b0}};
        pend_valid_nx = 1'b0;
        // A capture landing in APPLY is newer than anything buffered during BLANK.
        if (commit_req) begin
          shadow_nx  = sel_in;
          pending_nx = 1'b1;
          state_nx   = ST_ARMED;
        end else if (pend_valid) begin
          shadow_nx  = pend_buf;
          pending_nx = 1'b1;
          state_nx   = ST_ARMED;
        end else begin
          pending_nx = 1'b0;
          state_nx   = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      shadow     <= SEL_ALL_OFF;
      pend_buf   <= SEL_ALL_OFF;
      pend_valid <= 1'b0;
      mask       <= {NUM_PORTS{1'b0}};
      blank_cnt  <= {CNT_W{1'b0}};
      sel_active <= SEL_ALL_OFF;
      switch_cnt <= 16'd0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      commit_ack <= 1'b0;
    end else begin
      state      <= state_nx;
      shadow     <= shadow_nx;
      pend_buf   <= pend_buf_nx;
      pend_valid <= pend_valid_nx;
      mask       <= mask_nx;
      blank_cnt  <= blank_cnt_nx;
      sel_active <= sel_active_nx;
      switch_cnt <= switch_cnt_nx;
      pending    <= pending_nx;
      busy       <= (state_nx != ST_IDLE);
      commit_ack <= commit_req;
    end
  end

  // In APPLY the ports already take the new select so blanking lasts exactly BLANK_CYCLES.
  assign port_sel   = (state == ST_APPLY) ? shadow : sel_active;
  assign port_blank = (state == ST_BLANK) ? mask : {NUM_PORTS{1'b0}};

  for (genvar d = 0; d < NUM_PORTS; d++) begin : g_port
    amdc_pwm_mux_port #(
      .NUM_PORTS (NUM_PORTS),
      .LINES     (LINES)
    ) u_port (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .sel     (port_sel[d*4 +: 4]),
      .blank   (port_blank[d]),
      .pwm_in  (pwm_in),
      .pwm_out (pwm_out[d*LINES +: LINES])
    );
  end

endmodule

// File: tb/tb_amdc_pwm_mux_switcher.sv
// Directed bench for amdc_pwm_mux_switcher with default parameters (8 ports, 6 lines, 100 blank cycles).
module tb_amdc_pwm_mux_switcher;

  localparam int NP = 8;
  localparam int L  = 6;
  localparam int BC = 100;

  logic            ACLK;
  logic            ARESET;
  logic [4*NP-1:0] sel_in;
  logic            commit_req;
  logic            commit_ack;
  logic            carrier_sync;
  logic [NP*L-1:0] pwm_in;
  logic [NP*L-1:0] pwm_out;
  logic            busy;
  logic            pending;
  logic [4*NP-1:0] sel_active;
  logic [15:0]     switch_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int tick    = 0;
  int last_t  = 0;

  amdc_pwm_mux_switcher #(.NUM_PORTS(NP), .LINES(L), .BLANK_CYCLES(BC)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .sel_in       (sel_in),
    .commit_req   (commit_req),
    .commit_ack   (commit_ack),
    .carrier_sync (carrier_sync),
    .pwm_in       (pwm_in),
    .pwm_out      (pwm_out),
    .busy         (busy),
    .pending      (pending),
    .sel_active   (sel_active),
    .switch_cnt   (switch_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Each source has a distinct 6-bit pattern that inverts every cycle.
  function automatic logic [L-1:0] src_val(input logic [3:0] s, input int t);
    logic [L-1:0] b;
    b = {s[2:0], ~s[2:0]};
    return t[0] ? ~b : b;
  endfunction

  function automatic logic [NP*L-1:0] exp_out(input logic [4*NP-1:0] sel, input logic [NP-1:0] blank, input int t);
    logic [NP*L-1:0] r;
    logic [3:0]      s;
    r = '0;
    for (int d = 0; d < NP; d++) begin
      s = sel[d*4 +: 4];
      if (s < 4'd8 && !blank[d]) r[d*L +: L] = src_val(s, t);
    end
    return r;
  endfunction

  function automatic logic [NP-1:0] changed(input logic [4*NP-1:0] osel, input logic [4*NP-1:0] nsel);
    logic [NP-1:0] m;
    for (int d = 0; d < NP; d++) m[d] = (osel[d*4 +: 4] != nsel[d*4 +: 4]);
    return m;
  endfunction

  task automatic drive_pwm(input int t);
    for (int s = 0; s < NP; s++) pwm_in[s*L +: L] = src_val(4'(s), t);
  endtask

  // One clock: outputs are sampled on the falling edge, then the sources advance.
  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
    last_t = tick;
    tick++;
    drive_pwm(tick);
  endtask

  task automatic commit(input logic [4*NP-1:0] s);
    sel_in     = s;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
  endtask

  // Sync pulse, then per-cycle check of the blank window and the switch-over edge.
  task automatic apply_switch(input logic [4*NP-1:0] osel, input logic [4*NP-1:0] nsel, input string tag);
    logic [NP-1:0] m;
    m = changed(osel, nsel);
    carrier_sync = 1'b1;
    step();
    carrier_sync = 1'b0;
    check_eq({tag, "_sync"}, 64'(pwm_out), 64'(exp_out(osel, '0, last_t)));
    if (m != '0) begin
      for (int i = 0; i < BC; i++) begin
        step();
        check_eq({tag, "_blank"}, 64'(pwm_out), 64'(exp_out(osel, m, last_t)));
      end
    end
    step();
    check_eq({tag, "_apply"}, 64'(pwm_out), 64'(exp_out(nsel, '0, last_t)));
    check_eq({tag, "_sel"}, 64'(sel_active), 64'(nsel));
  endtask

  initial begin
    ARESET       = 1'b1;
    commit_req   = 1'b0;
    carrier_sync = 1'b0;
    sel_in       = 32'hFFFF_FFFF;
    drive_pwm(0);
    step();
    step();
    ARESET = 1'b0;
    check_eq("rst_pwm", 64'(pwm_out), 64'd0);
    check_eq("rst_sel", 64'(sel_active), 64'hFFFF_FFFF);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_pend", 64'(pending), 64'd0);
    check_eq("rst_cnt", 64'(switch_cnt), 64'd0);
    check_eq("rst_ack", 64'(commit_ack), 64'd0);

    // First routing from the all-disabled state.
    commit(32'h7654_3210);
    check_eq("c1_ack", 64'(commit_ack), 64'd1);
    check_eq("c1_pend", 64'(pending), 64'd1);
    check_eq("c1_busy", 64'(busy), 64'd1);
    step();
    check_eq("c1_ack_pulse", 64'(commit_ack), 64'd0);
    apply_switch(32'hFFFF_FFFF, 32'h7654_3210, "t1");
    check_eq("t1_cnt", 64'(switch_cnt), 64'd1);
    check_eq("t1_busy", 64'(busy), 64'd0);
    check_eq("t1_pend", 64'(pending), 64'd0);

    // Swap sources of ports 0 and 1 only.
    commit(32'h7654_3201);
    apply_switch(32'h7654_3210, 32'h7654_3201, "t2");
    check_eq("t2_cnt", 64'(switch_cnt), 64'd2);

    // Two commits while armed: the latest wins, single increment.
    commit(32'h7654_3211);
    commit(32'h7654_3222);
    apply_switch(32'h7654_3201, 32'h7654_3222, "t3");
    check_eq("t3_port0", 64'(sel_active[3:0]), 64'd2);
    check_eq("t3_cnt", 64'(switch_cnt), 64'd3);

    // Commit during BLANK is held and applied on the next sync.
    commit(32'h7654_3210);
    carrier_sync = 1'b1;
    step();
    carrier_sync = 1'b0;
    for (int i = 0; i < 10; i++) step();
    commit(32'h7654_3211);
    check_eq("t4_pend", 64'(pending), 64'd1);
    check_eq("t4_ack", 64'(commit_ack), 64'd1);
    for (int i = 0; i < 90; i++) step();
    check_eq("t4_sel1", 64'(sel_active), 64'h7654_3210);
    check_eq("t4_cnt1", 64'(switch_cnt), 64'd4);
    check_eq("t4_busy", 64'(busy), 64'd1);
    check_eq("t4_pend2", 64'(pending), 64'd1);
    apply_switch(32'h7654_3210, 32'h7654_3211, "t4");
    check_eq("t4_cnt2", 64'(switch_cnt), 64'd5);
    check_eq("t4_pend3", 64'(pending), 64'd0);

    // Identical select: no blanking, still counted.
    commit(32'h7654_3211);
    apply_switch(32'h7654_3211, 32'h7654_3211, "t5");
    check_eq("t5_cnt", 64'(switch_cnt), 64'd6);

    // Back-to-back identical switches up to 0xFFFF, then one more wraps to 0.
    sel_in       = 32'h7654_3211;
    commit_req   = 1'b1;
    carrier_sync = 1'b1;
    for (int i = 0; i < 131059; i++) step();
    check_eq("t6_max", 64'(switch_cnt), 64'hFFFF);
    commit_req = 1'b0;
    step();
    carrier_sync = 1'b0;
    step();
    check_eq("t6_wrap", 64'(switch_cnt), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_pwm", 64'(pwm_out), 64'(exp_out(32'h7654_3211, '0, last_t)));

    // Reset in the middle of a blank window with a pending select queued.
    commit(32'h7654_3210);
    carrier_sync = 1'b1;
    step();
    carrier_sync = 1'b0;
    for (int i = 0; i < 10; i++) step();
    commit(32'h0123_4567);
    for (int i = 0; i < 39; i++) step();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check_eq("t7_pwm", 64'(pwm_out), 64'd0);
    check_eq("t7_sel", 64'(sel_active), 64'hFFFF_FFFF);
    check_eq("t7_busy", 64'(busy), 64'd0);
    check_eq("t7_pend", 64'(pending), 64'd0);
    check_eq("t7_cnt", 64'(switch_cnt), 64'd0);
    for (int i = 0; i < 3; i++) step();
    check_eq("t7_busy_after", 64'(busy), 64'd0);
    check_eq("t7_pend_after", 64'(pending), 64'd0);
    check_eq("t7_pwm_after", 64'(pwm_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amdc_pwm_mux_switcher.md
AMDC_PWM_MUX_SWITCHER -- requirements
Module: amdc_pwm_mux_switcher

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8, meaning the number of inverter sources and the number of output ports.
REQ-002 SHALL have parameter LINES, default 6, meaning PWM lines per port.
REQ-003 SHALL have parameter BLANK_CYCLES, default 100, meaning forced-low blanking length in ACLK cycles (1..65535).
REQ-004 SHALL have port ACLK, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port ARESET, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port sel_in, input, 4*NUM_PORTS, meaning a 4-bit select per output port: 0..NUM_PORTS-1 = source index; any other value = disabled.
REQ-007 SHALL have port commit_req, input, 1, meaning a request to adopt sel_in.
REQ-008 SHALL have port commit_ack, output, 1, meaning a one-cycle pulse when sel_in is captured.
REQ-009 SHALL have port carrier_sync, input, 1, meaning a one-cycle pulse at the PWM carrier peak.
REQ-010 SHALL have port pwm_in, input, NUM_PORTS*LINES, meaning source gate signals.
REQ-011 SHALL have port pwm_out, output, NUM_PORTS*LINES, meaning muxed gate signals.
REQ-012 SHALL have port busy, output, 1, meaning FSM not IDLE.
REQ-013 SHALL have port pending, output, 1, meaning a captured select awaits application.
REQ-014 SHALL have port sel_active, output, 4*NUM_PORTS, meaning the currently applied select.
REQ-015 SHALL have port switch_cnt, output, 16, meaning the count of completed APPLYs; wraps at 0xFFFF->0.

Function
REQ-016 SHALL generate pwm_out registered: port d lines = pwm_in of source sel_active[d], else 0 if disabled or blanked. Latency is 1 cycle.
REQ-017 SHALL capture commit_req when it is high, sel_in into shadow, and pulse commit_ack the next cycle. commit_req is accepted in every state.
REQ-018 SHALL use FSM states IDLE, ARMED, BLANK and APPLY. Transitions:
- IDLE->ARMED on capture.
- ARMED->BLANK on carrier_sync.
- BLANK->APPLY when the blank counter reaches BLANK_CYCLES-1.
- APPLY->IDLE after 1 cycle, or APPLY->ARMED if pending is set.
REQ-019 SHALL in ARMED make a new capture overwrite the shadow, with the latest select winning.
REQ-020 SHALL in BLANK or APPLY hold a new capture in a second pending buffer and apply it on the next pass.
REQ-021 SHALL on entering BLANK latch the changed-port mask (shadow != sel_active per port).
- Only masked ports are forced low for exactly BLANK_CYCLES cycles.
- Unmasked ports keep passing through without interruption.
REQ-022 SHALL in APPLY load sel_active <= shadow and increment switch_cnt.
REQ-023 SHALL, if the changed mask is all-zero on BLANK entry, go directly to APPLY with no blanking; switch_cnt still increments.
REQ-024 SHALL, when carrier_sync and commit_req coincide in ARMED, enter BLANK with the newly captured select.
REQ-025 SHALL ignore carrier_sync in IDLE, BLANK and APPLY.
REQ-026 SHALL assert pending from capture until the APPLY that consumes it.

Reset
REQ-027 SHALL while ARESET is high, on each ACLK edge:
- set state=IDLE;
- set shadow, pending buffer and sel_active to all 0xF (disabled);
- set pwm_out=0, commit_ack=0, busy=0, pending=0, switch_cnt=0;
- clear the blank counter.
REQ-028 SHALL on reset mid-BLANK force all outputs low in the next cycle and discard the pending select.

Structure
REQ-029 SHALL place the FSM state enum, SEL_DISABLED=4'hF and the counter width constant in package amdc_pwm_mux_pkg.
REQ-030 SHALL instantiate one sub-module, amdc_pwm_mux_port, once per output port. Each instance selects its source and applies the blank gate and output register.

Verification
REQ-031 SHALL cover: reset, then sel_in=0x76543210, commit, sync -> after 100 blank cycles pwm_out port d follows source d; switch_cnt=1.
REQ-032 SHALL cover: active 0x76543210, commit 0x76543201 -> only ports 0 and 1 are low for exactly 100 cycles after sync; ports 2..7 toggle uninterrupted.
REQ-033 SHALL cover: two commits in ARMED (0x...11 then 0x...22) -> after sync sel_active port0=2, with a single switch_cnt increment.
REQ-034 SHALL cover: a commit during BLANK -> pending=1, APPLY->ARMED; the second sync applies it; switch_cnt increments by 2 total.
REQ-035 SHALL cover: ARESET pulsed at blank cycle 50 -> pwm_out=0 next cycle, sel_active=0xFFFFFFFF, busy=0, pending=0.
REQ-036 SHALL cover: committing an identical select -> no blanking, APPLY directly, and switch_cnt wraps from 0xFFFF to 0 when preloaded by 65535 switches.
